// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern generator / response compactor.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] SIG_POLY = 16'h1021;
    localparam logic [15:0] DEF_POLY = 16'hB400;
    localparam logic [15:0] DEF_SEED = 16'hACE1;

    // A zero seed would lock the LFSR, so it is replaced by the default seed.
    function automatic logic [15:0] pick_seed(input logic [15:0] value, input logic [15:0] fallback);
        return (value == 16'h0000) ? fallback : value;
    endfunction

endpackage

// File: rtl/lfsr16_step.sv
// Combinational next-state of a 16-bit shift register with XOR feedback mask.
// SHIFT_LEFT=0 gives a right-shifting Galois LFSR, SHIFT_LEFT=1 a left-shifting serial compactor.
module lfsr16_step #(
    parameter logic [15:0] MASK       = 16'h1021,
    parameter bit          SHIFT_LEFT = 1'b1
) (
    input  logic [15:0] cur,
    input  logic        serial_in,
    output logic [15:0] next
);

    logic fb;

    always_comb begin
        fb   = 1'b0;
        next = 16'h0000;
        if (SHIFT_LEFT) begin
            fb   = cur[15] ^ serial_in;
            next = {cur[14:0], 1'b0} ^ (fb ? MASK : 16'h0000);
        end else begin
            fb   = cur[0] ^ serial_in;
            next = {1'b0, cur[15:1]} ^ (fb ? MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/bist_tpg_ctrl.sv
// BIST pattern generator and signature/ones-count compactor for a 16-input CUT.
// Optional macro BIST_TPG_ZERO_PATTERN_EN appends one all-zero pattern to every run.
module bist_tpg_ctrl
    import bist_pkg::*;
#(
    parameter logic [15:0] SEED         = DEF_SEED,
    parameter logic [15:0] POLY         = DEF_POLY,
    parameter int unsigned NUM_PATTERNS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    output logic [15:0] pattern,
    output logic        pattern_valid,
    input  logic        cut_resp,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic [16:0] ones_count
);

    localparam logic [15:0] LAST = 16'(NUM_PATTERNS - 1);

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] seed_reg;
    logic [15:0] count;
    logic [15:0] lfsr_nxt;
    logic [15:0] sig_nxt;

    lfsr16_step #(.MASK(POLY), .SHIFT_LEFT(1'b0)) u_lfsr_step (
        .cur       (lfsr),
        .serial_in (1'b0),
        .next      (lfsr_nxt)
    );

    lfsr16_step #(.MASK(SIG_POLY), .SHIFT_LEFT(1'b1)) u_sig_step (
        .cur       (signature),
        .serial_in (cut_resp),
        .next      (sig_nxt)
    );

    // pattern_valid is never set in IDLE, so the compaction below cannot collide with the clear on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lfsr          <= SEED;
            seed_reg      <= SEED;
            count         <= 16'h0000;
            pattern       <= 16'h0000;
            pattern_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            signature     <= 16'h0000;
            ones_count    <= 17'h00000;
        end else begin
            if (pattern_valid) begin
                signature <= sig_nxt;
                if (cut_resp && ones_count != '1)
                    ones_count <= ones_count + 17'd1;
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (seed_load)
                        seed_reg <= pick_seed(seed_in, SEED);
                    if (start) begin
                        state         <= RUN;
                        lfsr          <= seed_reg;
                        pattern       <= seed_reg;
                        pattern_valid <= 1'b1;
                        busy          <= 1'b1;
                        count         <= 16'h0000;
                        signature     <= 16'h0000;
                        ones_count    <= 17'h00000;
                    end
                end

                RUN: begin
                    lfsr <= lfsr_nxt;
                    if (count == LAST) begin
                        busy    <= 1'b0;
                        pattern <= 16'h0000;
`ifdef BIST_TPG_ZERO_PATTERN_EN
                        state         <= ZERO;
                        pattern_valid <= 1'b1;
`else
                        state         <= DONE;
                        pattern_valid <= 1'b0;
                        done          <= 1'b1;
`endif
                    end else begin
                        pattern <= lfsr_nxt;
                        count   <= count + 16'd1;
                    end
                end

`ifdef BIST_TPG_ZERO_PATTERN_EN
                ZERO: begin
                    state         <= DONE;
                    pattern_valid <= 1'b0;
                    done          <= 1'b1;
                end
`endif

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state         <= IDLE;
                    pattern       <= 16'h0000;
                    pattern_valid <= 1'b0;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                end
            endcase
        end
    end

endmodule
